// File: rtl/qracc_sequencer.sv
// Sequences one job: per vector, read LOADW buffer words, issue one MAC vector, await the result, write STOREW words.
// Buffer strobes follow buf_ready_i in the same cycle; read data lands one cycle later; mac_valid_o holds until mac_ready_i.
module qracc_sequencer #(
  parameter int inputBits      = 4,
  parameter int inputElements  = 128,
  parameter int outputBits     = 8,
  parameter int outputElements = 32,
  parameter int bufWidth       = 32,
  parameter int addrWidth      = 32
) (
  input  logic                                   clk,
  input  logic                                   nrst,
  input  logic                                   start_i,
  input  logic [15:0]                            num_vec_i,
  input  logic [addrWidth-1:0]                   ibuf_base_i,
  input  logic [addrWidth-1:0]                   obuf_base_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  input  logic                                   buf_ready_i,
  output logic                                   buf_rd_en_o,
  output logic [addrWidth-1:0]                   buf_rd_addr_o,
  input  logic [bufWidth-1:0]                    buf_rd_data_i,
  output logic                                   buf_wr_en_o,
  output logic [addrWidth-1:0]                   buf_wr_addr_o,
  output logic [bufWidth-1:0]                    buf_wr_data_o,
  output logic                                   mac_valid_o,
  output logic [inputElements*inputBits-1:0]     mac_data_o,
  input  logic                                   mac_ready_i,
  input  logic                                   mac_out_valid_i,
  input  logic [outputElements*outputBits-1:0]   mac_out_data_i
);

  localparam int ACTW   = inputElements * inputBits;
  localparam int RESW   = outputElements * outputBits;
  localparam int LOADW  = ACTW / bufWidth;
  localparam int STOREW = RESW / bufWidth;
  localparam int RCW    = $clog2(LOADW + 1);
  localparam int SCW    = $clog2(STOREW + 1);

  localparam logic [addrWidth-1:0] STEP       = addrWidth'(bufWidth / 8);
  localparam logic [RCW-1:0]       RD_ALL     = RCW'(LOADW);
  localparam logic [RCW-1:0]       CAP_LAST   = RCW'(LOADW - 1);
  localparam logic [SCW-1:0]       WR_LAST    = SCW'(STOREW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_STORE, S_DONE
  } state_t;

  state_t                r_state;
  logic [15:0]           r_num;
  logic [15:0]           r_vec;
  logic [RCW-1:0]        r_rd_cnt;
  logic [RCW-1:0]        r_cap_cnt;
  logic                  r_rd_pend;
  logic [SCW-1:0]        r_wr_cnt;
  logic [addrWidth-1:0]  r_rd_addr;
  logic [addrWidth-1:0]  r_wr_addr;
  logic [ACTW-1:0]       r_act;
  logic [RESW-1:0]       r_res;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_mac_valid;

  logic                  w_rd_en;
  logic                  w_wr_en;
  logic [15:0]           w_vec_nxt;

  // Word index is global across the job, so running pointers give base + (vec*N + w)*bytes.
  assign w_rd_en   = (r_state == S_LOAD) && buf_ready_i && (r_rd_cnt != RD_ALL);
  assign w_wr_en   = (r_state == S_STORE) && buf_ready_i;
  assign w_vec_nxt = r_vec + 16'd1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_vec       <= '0;
      r_rd_cnt    <= '0;
      r_cap_cnt   <= '0;
      r_rd_pend   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_act       <= '0;
      r_res       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mac_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_num     <= num_vec_i;
            r_rd_addr <= ibuf_base_i;
            r_wr_addr <= obuf_base_i;
            r_vec     <= '0;
            r_rd_cnt  <= '0;
            r_cap_cnt <= '0;
            r_rd_pend <= 1'b0;
            r_wr_cnt  <= '0;
            r_busy    <= 1'b1;
            if (num_vec_i == 16'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          r_rd_pend <= w_rd_en;
          if (w_rd_en) begin
            r_rd_cnt  <= r_rd_cnt + 1'b1;
            r_rd_addr <= r_rd_addr + STEP;
          end
          // Shift in from the top so word w ends up at bits [w*bufWidth +: bufWidth].
          if (r_rd_pend) begin
            r_act     <= {buf_rd_data_i, r_act[ACTW-1:bufWidth]};
            r_cap_cnt <= r_cap_cnt + 1'b1;
            if (r_cap_cnt == CAP_LAST) begin
              r_state     <= S_ISSUE;
              r_mac_valid <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          if (mac_ready_i) begin
            r_mac_valid <= 1'b0;
            r_state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (mac_out_valid_i) begin
            r_res    <= mac_out_data_i;
            r_wr_cnt <= '0;
            r_state  <= S_STORE;
          end
        end

        S_STORE: begin
          if (w_wr_en) begin
            r_res     <= r_res >> bufWidth;
            r_wr_addr <= r_wr_addr + STEP;
            r_wr_cnt  <= r_wr_cnt + 1'b1;
            if (r_wr_cnt == WR_LAST) begin
              r_vec    <= w_vec_nxt;
              r_wr_cnt <= '0;
              if (w_vec_nxt < r_num) begin
                r_state   <= S_LOAD;
                r_rd_cnt  <= '0;
                r_cap_cnt <= '0;
                r_rd_pend <= 1'b0;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_mac_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign buf_rd_en_o   = w_rd_en;
  assign buf_rd_addr_o = w_rd_en ? r_rd_addr : '0;
  assign buf_wr_en_o   = w_wr_en;
  assign buf_wr_addr_o = w_wr_en ? r_wr_addr : '0;
  assign buf_wr_data_o = w_wr_en ? r_res[bufWidth-1:0] : '0;
  assign mac_valid_o   = r_mac_valid;
  assign mac_data_o    = r_mac_valid ? r_act : '0;

endmodule

// File: tb/tb_qracc_sequencer.sv
// Randomized bench for qracc_sequencer: emulates buffer memory and accelerator, checks against a job-level model.
module tb_qracc_sequencer;

  localparam int BW = 32, AW = 32, LOADW = 16, STOREW = 8, ACTW = 512, RESW = 256;

  logic            clk = 1'b0;
  logic            nrst;
  logic            start_i;
  logic [15:0]     num_vec_i;
  logic [AW-1:0]   ibuf_base_i, obuf_base_i;
  logic            busy_o, done_o;
  logic            buf_ready_i;
  logic            buf_rd_en_o;
  logic [AW-1:0]   buf_rd_addr_o;
  logic [BW-1:0]   buf_rd_data_i;
  logic            buf_wr_en_o;
  logic [AW-1:0]   buf_wr_addr_o;
  logic [BW-1:0]   buf_wr_data_o;
  logic            mac_valid_o;
  logic [ACTW-1:0] mac_data_o;
  logic            mac_ready_i;
  logic            mac_out_valid_i;
  logic [RESW-1:0] mac_out_data_i;

  qracc_sequencer dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .num_vec_i(num_vec_i),
    .ibuf_base_i(ibuf_base_i), .obuf_base_i(obuf_base_i),
    .busy_o(busy_o), .done_o(done_o), .buf_ready_i(buf_ready_i),
    .buf_rd_en_o(buf_rd_en_o), .buf_rd_addr_o(buf_rd_addr_o), .buf_rd_data_i(buf_rd_data_i),
    .buf_wr_en_o(buf_wr_en_o), .buf_wr_addr_o(buf_wr_addr_o), .buf_wr_data_o(buf_wr_data_o),
    .mac_valid_o(mac_valid_o), .mac_data_o(mac_data_o), .mac_ready_i(mac_ready_i),
    .mac_out_valid_i(mac_out_valid_i), .mac_out_data_i(mac_out_data_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0]     exp_ra[$], exp_wa[$], exp_wd[$], rd_log[$];
  logic [ACTW-1:0] exp_mac[$];
  bit              model_busy = 1'b0;
  int              rd_seen, wr_seen, mac_seen, done_seen, busy_cycles, mv_cycles;
  bit              resp_pend = 1'b0;
  logic [31:0]     resp_addr = '0;
  bit              acc_pend = 1'b0;
  int              acc_dly = 0;
  logic [RESW-1:0] acc_res = '0;
  bit              prev_stall = 1'b0;
  logic [ACTW-1:0] prev_data = '0;
  int              rdy_mode = 0, mac_mode = 0, acc_max = 0, hold_cnt = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [RESW-1:0] accf(input logic [ACTW-1:0] a);
    return a[RESW-1:0] ^ a[ACTW-1:RESW] ^ {8{32'hC3A50F1E}};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_rd_en"}, 32'(buf_rd_en_o), 32'd0);
    chk({tag, "_rd_addr"}, buf_rd_addr_o, 32'd0);
    chk({tag, "_wr_en"}, 32'(buf_wr_en_o), 32'd0);
    chk({tag, "_wr_addr"}, buf_wr_addr_o, 32'd0);
    chk({tag, "_wr_data"}, buf_wr_data_o, 32'd0);
    chk({tag, "_mac_valid"}, 32'(mac_valid_o), 32'd0);
    chk({tag, "_mac_data_or"}, 32'(|mac_data_o), 32'd0);
  endtask

  // Expected traffic of a whole job, straight from the address/packing rules.
  task automatic build_job(input logic [15:0] n, input logic [31:0] ib, input logic [31:0] ob);
    logic [ACTW-1:0] act;
    logic [RESW-1:0] res;
    logic [31:0]     a;
    for (int v = 0; v < int'(n); v++) begin
      act = '0;
      for (int w = 0; w < LOADW; w++) begin
        a = ib + 32'((v * LOADW + w) * (BW / 8));
        exp_ra.push_back(a);
        act[w*BW +: BW] = memf(a);
      end
      exp_mac.push_back(act);
      res = accf(act);
      for (int w = 0; w < STOREW; w++) begin
        exp_wa.push_back(ob + 32'((v * STOREW + w) * (BW / 8)));
        exp_wd.push_back(res[w*BW +: BW]);
      end
    end
  endtask

  task automatic model_clear();
    exp_ra.delete(); exp_wa.delete(); exp_wd.delete(); exp_mac.delete();
    model_busy = 1'b0; resp_pend = 1'b0; acc_pend = 1'b0; prev_stall = 1'b0;
  endtask

  // Stimulus driver: all DUT inputs except job control change just after the rising edge.
  initial begin
    buf_ready_i = 1'b0; mac_ready_i = 1'b0; buf_rd_data_i = '0;
    mac_out_valid_i = 1'b0; mac_out_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       buf_ready_i = 1'b1;
        1:       buf_ready_i = ~buf_ready_i;
        default: buf_ready_i = ($urandom_range(0, 3) != 0);
      endcase
      if (mac_mode == 2) begin
        if (mac_valid_o) begin
          if (hold_cnt < 10) begin mac_ready_i = 1'b0; hold_cnt++; end
          else mac_ready_i = 1'b1;
        end else begin
          hold_cnt = 0;
          mac_ready_i = 1'b0;
        end
      end else if (mac_mode == 1) mac_ready_i = $urandom_range(0, 1) != 0;
      else mac_ready_i = 1'b1;
      buf_rd_data_i = resp_pend ? memf(resp_addr) : $urandom;
      if (acc_pend) begin
        if (acc_dly == 0) begin
          mac_out_valid_i = 1'b1; mac_out_data_i = acc_res; acc_pend = 1'b0;
        end else begin
          acc_dly--; mac_out_valid_i = 1'b0;
          mac_out_data_i = {8{$urandom}};
        end
      end else begin
        mac_out_valid_i = ($urandom_range(0, 7) == 0);
        mac_out_data_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Compare process: every cycle, outputs against the job model.
  always @(negedge clk) begin
    if (nrst) begin
      chk("busy", 32'(busy_o), 32'(model_busy));
      chk("rd_wr_excl", 32'(buf_rd_en_o & buf_wr_en_o), 32'd0);
      if (busy_o) busy_cycles++;
      resp_pend = 1'b0;
      if (buf_rd_en_o) begin
        rd_seen++;
        rd_log.push_back(buf_rd_addr_o);
        resp_pend = 1'b1;
        resp_addr = buf_rd_addr_o;
        if (exp_ra.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else chk("rd_addr", buf_rd_addr_o, exp_ra.pop_front());
      end
      if (buf_wr_en_o) begin
        wr_seen++;
        if (exp_wa.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          chk("wr_addr", buf_wr_addr_o, exp_wa.pop_front());
          chk("wr_data", buf_wr_data_o, exp_wd.pop_front());
        end
      end
      if (prev_stall) begin
        checks++;
        if (!mac_valid_o || mac_data_o !== prev_data) begin
          errors++;
          $display("FAIL mac_hold valid %0d data %h exp %h", mac_valid_o, mac_data_o, prev_data);
        end
      end
      if (mac_valid_o) begin
        mv_cycles++;
        if (mac_ready_i) begin
          mac_seen++;
          if (exp_mac.size() == 0) chk("mac_unexpected", 32'd1, 32'd0);
          else begin
            checks++;
            if (mac_data_o !== exp_mac[0]) begin
              errors++;
              $display("FAIL mac_data got %h exp %h", mac_data_o, exp_mac[0]);
            end
            void'(exp_mac.pop_front());
          end
          acc_pend = 1'b1;
          acc_res  = accf(mac_data_o);
          acc_dly  = $urandom_range(0, acc_max);
        end
      end
      prev_stall = mac_valid_o && !mac_ready_i;
      prev_data  = mac_data_o;
      if (done_o) begin
        done_seen++;
        chk("done_when_complete", 32'(model_busy && exp_ra.size() == 0 && exp_wa.size() == 0
                                      && exp_mac.size() == 0), 32'd1);
        model_busy = 1'b0;
      end else if (start_i && !model_busy) begin
        model_busy = 1'b1;
        build_job(num_vec_i, ibuf_base_i, obuf_base_i);
      end
    end
  end

  task automatic start_job(input logic [15:0] n, input logic [31:0] ib, input logic [31:0] ob);
    rd_seen = 0; wr_seen = 0; mac_seen = 0; done_seen = 0; busy_cycles = 0; mv_cycles = 0;
    rd_log.delete();
    @(posedge clk); #2;
    num_vec_i = n; ibuf_base_i = ib; obuf_base_i = ob; start_i = 1'b1;
    @(posedge clk); #2;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_seen == 0 && k < budget) begin
      @(posedge clk); #3;
      k++;
    end
    if (done_seen == 0) chk("done_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    nrst = 1'b0; start_i = 1'b0; num_vec_i = '0; ibuf_base_i = '0; obuf_base_i = '0;
    repeat (3) @(posedge clk);
    #3 chk_outputs_zero("reset");
    @(posedge clk); #2 nrst = 1'b1;

    // Single vector, everything ready, zero accelerator delay.
    rdy_mode = 0; mac_mode = 0; acc_max = 0;
    start_job(16'd1, 32'h100, 32'h200);
    wait_done(3000);
    chk("a_reads", 32'(rd_seen), 32'd16);
    chk("a_writes", 32'(wr_seen), 32'd8);
    chk("a_macs", 32'(mac_seen), 32'd1);
    chk("a_dones", 32'(done_seen), 32'd1);
    chk("a_busy_cycles", 32'(busy_cycles), 32'd28);
    if (rd_log.size() == 16) begin
      chk("a_first_rd", rd_log[0], 32'h100);
      chk("a_last_rd", rd_log[15], 32'h13C);
    end else chk("a_rd_log_size", 32'(rd_log.size()), 32'd16);

    // Empty job.
    start_job(16'd0, 32'h300, 32'h400);
    wait_done(50);
    chk("b_reads", 32'(rd_seen), 32'd0);
    chk("b_writes", 32'(wr_seen), 32'd0);
    chk("b_mv_cycles", 32'(mv_cycles), 32'd0);
    chk("b_busy_cycles", 32'(busy_cycles), 32'd1);
    chk("b_dones", 32'(done_seen), 32'd1);

    // Three vectors, buffer ready toggling.
    rdy_mode = 1; mac_mode = 1; acc_max = 3;
    start_job(16'd3, 32'h1000, 32'h2000);
    wait_done(3000);
    chk("c_reads", 32'(rd_seen), 32'd48);
    chk("c_writes", 32'(wr_seen), 32'd24);

    // Accelerator stalls 10 cycles; a stray start arrives mid-job.
    rdy_mode = 0; mac_mode = 2; acc_max = 2;
    start_job(16'd1, 32'h500, 32'h600);
    repeat (5) @(posedge clk);
    #2 start_i = 1'b1; num_vec_i = 16'd5; ibuf_base_i = 32'hDEAD0000;
    @(posedge clk); #2 start_i = 1'b0;
    wait_done(3000);
    chk("d_mv_cycles", 32'(mv_cycles), 32'd11);
    chk("d_reads", 32'(rd_seen), 32'd16);

    // Read address wraps past the top of the address space.
    mac_mode = 0; acc_max = 0;
    start_job(16'd1, 32'hFFFFFFF8, 32'h700);
    wait_done(3000);
    if (rd_log.size() == 16) begin
      chk("e_rd0", rd_log[0], 32'hFFFFFFF8);
      chk("e_rd1", rd_log[1], 32'hFFFFFFFC);
      chk("e_rd2", rd_log[2], 32'h0);
      chk("e_rd15", rd_log[15], 32'h34);
    end else chk("e_rd_log_size", 32'(rd_log.size()), 32'd16);

    // Reset while storing vector 1, then a fresh job.
    start_job(16'd3, 32'h800, 32'h900);
    for (int k = 0; k < 3000 && wr_seen < 10; k++) begin
      @(posedge clk); #3;
    end
    chk("f_reached_store1", 32'(wr_seen >= 10), 32'd1);
    nrst = 1'b0;
    #1 chk_outputs_zero("midrst");
    model_clear();
    repeat (3) @(posedge clk);
    #2 nrst = 1'b1;
    start_job(16'd2, 32'h4000, 32'h8000);
    wait_done(3000);
    chk("f_reads", 32'(rd_seen), 32'd32);
    chk("f_writes", 32'(wr_seen), 32'd16);
    if (rd_log.size() > 0) chk("f_first_rd", rd_log[0], 32'h4000);
    else chk("f_rd_log_size", 32'(rd_log.size()), 32'd32);

    // Randomized jobs.
    for (int j = 0; j < 6; j++) begin
      logic [15:0] n;
      n = 16'($urandom_range(1, 3));
      rdy_mode = $urandom_range(0, 2); mac_mode = $urandom_range(0, 1); acc_max = $urandom_range(0, 4);
      start_job(n, $urandom, $urandom);
      wait_done(4000);
      chk("r_reads", 32'(rd_seen), 32'(int'(n) * LOADW));
      chk("r_writes", 32'(wr_seen), 32'(int'(n) * STOREW));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
